// File: rtl/fft_host_pkg.sv
// Shared types and constants for the FFT host-side sequencer.
package fft_host_pkg;

  localparam int NUM_SAMPLES = 4;
  localparam int NIBBLE_W    = 4;
  localparam int IDX_W       = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_HI,
    LOAD_LO,
    SETTLE,
    OUT_HI,
    OUT_WAIT,
    OUT_LO,
    DONE
  } host_state_t;

  // Timer reload value for a phase lasting n cycles (the counter expires on zero).
  function automatic logic [7:0] minus_one(input int n);
    return (n <= 0) ? 8'd0 : 8'(n - 1);
  endfunction

endpackage

// File: rtl/fft_host_driver_strobe_timer.sv
// 8-bit loadable down-counter shared by every timed phase of the host sequencer.
module strobe_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       count,
  output logic       expired
);

  logic [7:0] cnt_q, cnt_d;

  // Reload on phase entry, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (count && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == 8'd0);

endmodule

// File: rtl/fft_host_driver.sv
// Host-side sequencer: loads four sample bytes into the FFT engine, then
// strobes out four results and unpacks them into signed real/imag nibbles.
module fft_host_driver
  import fft_host_pkg::*;
#(
  parameter int PULSE_CYCLES  = 4,
  parameter int GAP_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int RX_TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] sample_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] result_real,
  output logic [15:0] result_imag,
  output logic        dut_load,
  output logic        dut_output,
  output logic [7:0]  dut_data,
  input  logic [7:0]  dut_rx,
  input  logic [7:0]  dut_rx_oe
);

  host_state_t        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               captured_q, captured_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               load_q, load_d;
  logic               out_q, out_d;
  logic [15:0]        real_q, real_d;
  logic [15:0]        imag_q, imag_d;
  logic [31:0]        samples_q;

  logic                       oe_ok;
  logic                       cap_now;
  logic                       tmr_load;
  logic [7:0]                 tmr_val;
  logic                       tmr_expired;
  logic signed [NIBBLE_W-1:0] rx_real;
  logic signed [NIBBLE_W-1:0] rx_imag;

  assign oe_ok   = (dut_rx_oe == 8'hFF);
  assign rx_real = dut_rx[7:4];
  assign rx_imag = dut_rx[3:0];

  strobe_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (state_q != IDLE),
    .expired  (tmr_expired)
  );

  // Next-state, capture and result bookkeeping for the whole transaction.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    captured_d = captured_q;
    err_d      = err_q;
    real_d     = real_q;
    imag_d     = imag_q;
    cap_now    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_HI;
          idx_d   = '0;
          err_d   = 1'b0;
          real_d  = '0;
          imag_d  = '0;
        end
      end
      LOAD_HI: begin
        if (tmr_expired) state_d = LOAD_LO;
      end
      LOAD_LO: begin
        if (tmr_expired) begin
          if (idx_q == IDX_W'(NUM_SAMPLES - 1)) begin
            idx_d   = '0;
            state_d = (SETTLE_CYCLES == 0) ? OUT_HI : SETTLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = LOAD_HI;
          end
        end
      end
      SETTLE: begin
        if (tmr_expired) state_d = OUT_HI;
      end
      OUT_HI: begin
        // A byte arriving in the last strobe cycle still counts as captured.
        cap_now = oe_ok && !captured_q;
        if (tmr_expired) state_d = (captured_q || cap_now) ? OUT_LO : OUT_WAIT;
      end
      OUT_WAIT: begin
        // Capture wins over timeout when both land on the same cycle.
        if (oe_ok && !captured_q) begin
          cap_now = 1'b1;
          state_d = OUT_LO;
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          state_d = OUT_LO;
        end
      end
      OUT_LO: begin
        if (tmr_expired) begin
          if (idx_q == IDX_W'(NUM_SAMPLES - 1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = OUT_HI;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (cap_now) begin
      captured_d = 1'b1;
      real_d[{idx_q, 2'b00} +: NIBBLE_W] = rx_real;
      imag_d[{idx_q, 2'b00} +: NIBBLE_W] = rx_imag;
    end
    if ((state_d == OUT_HI) && (state_q != OUT_HI)) captured_d = 1'b0;
  end

  // Timer reloads on every phase change with the length of the phase being entered.
  always_comb begin
    tmr_load = (state_d != state_q);
    case (state_d)
      LOAD_HI, OUT_HI: tmr_val = minus_one(PULSE_CYCLES);
      LOAD_LO, OUT_LO: tmr_val = minus_one(GAP_CYCLES);
      SETTLE:          tmr_val = minus_one(SETTLE_CYCLES);
      OUT_WAIT:        tmr_val = minus_one(RX_TIMEOUT);
      default:         tmr_val = 8'd0;
    endcase
  end

  // Strobes and done are registered decodes of the upcoming state.
  always_comb begin
    load_d = (state_d == LOAD_HI);
    out_d  = (state_d == OUT_HI);
    done_d = (state_d == DONE);
  end

  // Control, strobe and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      captured_q <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      load_q     <= 1'b0;
      out_q      <= 1'b0;
      real_q     <= '0;
      imag_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      captured_q <= captured_d;
      err_q      <= err_d;
      done_q     <= done_d;
      load_q     <= load_d;
      out_q      <= out_d;
      real_q     <= real_d;
      imag_q     <= imag_d;
    end
  end

  // Sample bytes are latched on an accepted start; they need no reset.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && start) samples_q <= sample_data;
  end

  // Data bus carries the current sample only while loading.
  always_comb begin
    dut_data = 8'h00;
    if ((state_q == LOAD_HI) || (state_q == LOAD_LO)) dut_data = samples_q[{idx_q, 3'b000} +: 8];
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign result_real = real_q;
  assign result_imag = imag_q;
  assign dut_load    = load_q;
  assign dut_output  = out_q;

endmodule
